axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI read master port (AR + R channels) among NREQ stream-side read requesters,
//  e.g. two AXI-to-stream buffer controllers feeding separate TX paths. Round-robin grant per burst;
//  one burst outstanding at a time. Routes the R beats of the granted burst back to its owner only.
//  Sits between the per-stream read controllers and the PS/HP AXI port.
// PARAMETERS
//  NREQ       2    number of requesters (2..4)
//  ADDR_W     32   AXI address width
//  BURST_LEN  16   expected beats per burst; AXI_arlen driven to BURST_LEN-1
//  ERRCNT_W   16   width of the saturating error counter
// PORTS
//  AXI_clk      in   1            single clock for the whole block
//  AXI_rst_n    in   1            reset, synchronous, active-low
//  req_araddr   in   NREQ*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
//  req_arvalid  in   NREQ         requester i has a burst to issue
//  req_arready  out  NREQ         AR handshake to requester i
//  req_rvalid   out  NREQ         R beat valid to requester i
//  req_rready   in   NREQ         requester i accepts beat
//  req_rlast    out  NREQ         last beat to requester i
//  AXI_araddr   out  ADDR_W       master address, registered
//  AXI_arlen    out  4            constant BURST_LEN-1
//  AXI_arvalid  out  1            master AR valid, registered
//  AXI_arready  in   1            slave AR ready
//  AXI_rvalid   in   1            slave R valid
//  AXI_rready   out  1            master R ready
//  AXI_rlast    in   1            slave last beat
//  grant        out  NREQ         one-hot owner of current burst, 0 when idle
//  len_err      out  1            one-cycle pulse: burst length mismatch or stray beat
//  err_cnt      out  ERRCNT_W     saturating count of len_err pulses
// BEHAVIOUR
//  Reset (AXI_rst_n=0 at clock edge): state=IDLE, AXI_arvalid=0, AXI_araddr=0, grant=0, beat cnt=0,
//   len_err=0, err_cnt=0, rr pointer=0 (requester 0 highest priority next). Reset mid-burst abandons
//   the burst; no completion is signalled to the requester.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if any req_arvalid, pick first set bit scanning from (last_grant+1) mod NREQ; register grant,
//   AXI_araddr<=req_araddr[g], AXI_arvalid<=1, go ADDR. Arbitration to AXI_arvalid = 1 cycle.
//   AXI_rready=1 in IDLE to drain stray beats; each stray beat (rvalid&rready) pulses len_err.
//  ADDR: AXI_arvalid held 1, address held constant. req_arready[g] = AXI_arready & AXI_arvalid
//   (combinational, same cycle as master handshake); on that handshake AXI_arvalid<=0, beat<=0,
//   go DATA. Requester deasserting arvalid in ADDR is ignored; the latched burst still issues.
//  DATA: AXI_rready = req_rready[g]; req_rvalid[g]=AXI_rvalid, req_rlast[g]=AXI_rlast; other
//   requesters see rvalid=rlast=0. beat increments on each handshake (width clog2(BURST_LEN)+1).
//   On handshake with AXI_rlast=1: if beat != BURST_LEN-1 pulse len_err; last_grant<=g, grant<=0,
//   go IDLE. rlast handshake with pending requests: one idle cycle, then next grant (no overlap).
//   Beat count reaching BURST_LEN without rlast: len_err pulse, stay DATA until rlast.
//  req_arready, req_rvalid, req_rlast are 0 for all requesters outside ADDR/DATA respectively.
//  err_cnt increments on every len_err, saturates at all-ones, cleared only by reset.
// STRUCTURE
//  Shared header a2s_axi_defs: state encodings, BURST_LEN default, AXI_arlen width, ADDR_W.
//  Sub-module rr_pick: combinational round-robin one-hot picker (req, last_grant -> grant).
//  Top holds FSM, address/grant registers, beat counter, R-channel mux/demux, error counter.
// TESTING
//  1 Reset: hold AXI_rst_n=0 3 cycles with all inputs active -> all outputs 0, AXI_rready=1.
//  2 Single req0 addr 0x1000_0040, arready after 2 cycles, 16 beats -> one AR at 0x1000_0040,
//    arlen=15, req_rvalid[0] 16 beats, req_rvalid[1]=0 throughout, len_err never.
//  3 req0 and req1 both held valid for 4 bursts -> grants 0,1,0,1; 1 idle cycle between bursts.
//  4 rlast on beat 8 -> len_err pulse on cycle after handshake, err_cnt=1, FSM back to IDLE.
//  5 Two stray rvalid beats in IDLE -> err_cnt=2, no req_rvalid asserted.
//  6 Assert reset at beat 5 of burst -> next cycle IDLE, grant=0; new req1 then served normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: FSM encoding, default geometry
// and the picker index-width helper.
package axi_rd_arbiter_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 16;
  localparam int ARLEN_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set, scanning upward from
// i_ptr with wrap-around. Returns one-hot grant plus its index.
module axi_rd_arbiter_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master among NREQ requesters, one burst in flight,
// round-robin per burst, R beats routed back to the owner only.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | no owner; drain stray R beats; arbitrate on any req_arvalid
//  ST_ADDR | AR issued for owner, waiting for AXI_arready
//  ST_DATA | R beats flow to owner until the rlast handshake
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ERRCNT_W  = 16
) (
  input  logic                     AXI_clk,
  input  logic                     AXI_rst_n,
  input  logic [NREQ*ADDR_W-1:0]   req_araddr,
  input  logic [NREQ-1:0]          req_arvalid,
  output logic [NREQ-1:0]          req_arready,
  output logic [NREQ-1:0]          req_rvalid,
  input  logic [NREQ-1:0]          req_rready,
  output logic [NREQ-1:0]          req_rlast,
  output logic [ADDR_W-1:0]        AXI_araddr,
  output logic [ARLEN_W-1:0]       AXI_arlen,
  output logic                     AXI_arvalid,
  input  logic                     AXI_arready,
  input  logic                     AXI_rvalid,
  output logic                     AXI_rready,
  input  logic                     AXI_rlast,
  output logic [NREQ-1:0]          grant,
  output logic                     len_err,
  output logic [ERRCNT_W-1:0]      err_cnt
);

  localparam int                IDX_W     = idx_width(NREQ);
  localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] FULL_BEAT = BEAT_W'(BURST_LEN);
  localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(NREQ - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [NREQ-1:0]     r_grant;
  logic [IDX_W-1:0]    r_gidx;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_len_err;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic [NREQ-1:0]     w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_err_evt;

  axi_rd_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req_arvalid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    AXI_rready  = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    req_rlast   = '0;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Always ready so a misbehaving slave cannot stall the bus; each beat is an error.
        AXI_rready = 1'b1;
        w_r_hs     = AXI_rvalid;
        w_err_evt  = AXI_rvalid;
        if (w_pick_any) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        w_ar_hs     = AXI_arready & r_arvalid;
        req_arready = r_grant & {NREQ{w_ar_hs}};
        if (w_ar_hs) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        AXI_rready = req_rready[r_gidx];
        w_r_hs     = AXI_rvalid & req_rready[r_gidx];
        req_rvalid = r_grant & {NREQ{AXI_rvalid}};
        req_rlast  = r_grant & {NREQ{AXI_rlast}};
        if (w_r_hs) begin
          if (AXI_rlast) begin
            w_err_evt   = (r_beat != LAST_BEAT);
            w_state_nxt = ST_IDLE;
          end else begin
            w_err_evt = (r_beat == LAST_BEAT);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_beat    <= '0;
      r_len_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_len_err <= w_err_evt;
      if (w_err_evt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant   <= w_pick_oh;
            r_gidx    <= w_pick_idx;
            r_araddr  <= req_araddr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_arvalid <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_beat    <= '0;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            if (AXI_rlast) begin
              r_grant  <= '0;
              r_rr_ptr <= (r_gidx == MAX_IDX) ? '0 : r_gidx + IDX_W'(1);
            end else if (r_beat != FULL_BEAT) begin
              // Held at FULL_BEAT on overrun so the trailing rlast still mismatches.
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign AXI_araddr  = r_araddr;
  assign AXI_arvalid = r_arvalid;
  assign AXI_arlen   = ARLEN_W'(BURST_LEN - 1);
  assign grant       = r_grant;
  assign len_err     = r_len_err;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: acts as requesters and AXI slave, checks against a
// burst-level model (round-robin order, expected error pulses, saturating count).
module tb_axi_rd_arbiter;

  localparam int NREQ      = 3;
  localparam int ADDR_W    = 32;
  localparam int BURST_LEN = 16;
  localparam int ERRCNT_W  = 3;
  localparam int ERR_MAX   = (1 << ERRCNT_W) - 1;

  logic                   AXI_clk;
  logic                   AXI_rst_n;
  logic [NREQ*ADDR_W-1:0] req_araddr;
  logic [NREQ-1:0]        req_arvalid;
  logic [NREQ-1:0]        req_arready;
  logic [NREQ-1:0]        req_rvalid;
  logic [NREQ-1:0]        req_rready;
  logic [NREQ-1:0]        req_rlast;
  logic [ADDR_W-1:0]      AXI_araddr;
  logic [3:0]             AXI_arlen;
  logic                   AXI_arvalid;
  logic                   AXI_arready;
  logic                   AXI_rvalid;
  logic                   AXI_rready;
  logic                   AXI_rlast;
  logic [NREQ-1:0]        grant;
  logic                   len_err;
  logic [ERRCNT_W-1:0]    err_cnt;

  axi_rd_arbiter #(
    .NREQ      (NREQ),
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .ERRCNT_W  (ERRCNT_W)
  ) dut (
    .AXI_clk     (AXI_clk),
    .AXI_rst_n   (AXI_rst_n),
    .req_araddr  (req_araddr),
    .req_arvalid (req_arvalid),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .req_rlast   (req_rlast),
    .AXI_araddr  (AXI_araddr),
    .AXI_arlen   (AXI_arlen),
    .AXI_arvalid (AXI_arvalid),
    .AXI_arready (AXI_arready),
    .AXI_rvalid  (AXI_rvalid),
    .AXI_rready  (AXI_rready),
    .AXI_rlast   (AXI_rlast),
    .grant       (grant),
    .len_err     (len_err),
    .err_cnt     (err_cnt)
  );

  initial AXI_clk = 1'b0;
  always #5 AXI_clk = ~AXI_clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int exp_ptr    = 0;
  int exp_err    = 0;
  int exp_pulses = 0;
  int n_pulses   = 0;
  logic [ADDR_W-1:0] addr_tab [NREQ];

  always @(negedge AXI_clk)
    if (AXI_rst_n === 1'b1 && len_err === 1'b1) n_pulses++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] reqs, input int ptr);
    for (int d = 0; d < NREQ; d++)
      if (reqs[(ptr + d) % NREQ]) return (ptr + d) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic note_err();
    exp_pulses++;
    if (exp_err < ERR_MAX) exp_err++;
  endtask

  task automatic drive_idle();
    req_arvalid = '0;
    req_rready  = '0;
    AXI_arready = 1'b0;
    AXI_rvalid  = 1'b0;
    AXI_rlast   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    AXI_rst_n   = 1'b0;
    req_arvalid = '1;
    req_rready  = '1;
    AXI_arready = 1'b1;
    AXI_rvalid  = 1'b1;
    AXI_rlast   = 1'b1;
    req_araddr  = {NREQ{32'hDEAD_BEEF}};
    repeat (n) @(negedge AXI_clk);
    check_eq("rst_grant",   64'(grant),       64'(0));
    check_eq("rst_arvalid", 64'(AXI_arvalid), 64'(0));
    check_eq("rst_araddr",  64'(AXI_araddr),  64'(0));
    check_eq("rst_len_err", 64'(len_err),     64'(0));
    check_eq("rst_err_cnt", 64'(err_cnt),     64'(0));
    check_eq("rst_arready", 64'(req_arready), 64'(0));
    check_eq("rst_rvalid",  64'(req_rvalid),  64'(0));
    check_eq("rst_rlast",   64'(req_rlast),   64'(0));
    check_eq("rst_rready",  64'(AXI_rready),  64'(1));
    check_eq("rst_arlen",   64'(AXI_arlen),   64'(BURST_LEN - 1));
    drive_idle();
    AXI_rst_n = 1'b1;
    exp_ptr   = 0;
    exp_err   = 0;
  endtask

  task automatic stray(input int k);
    req_arvalid = '0;
    for (int i = 0; i < k; i++) begin
      AXI_rvalid = 1'b1;
      AXI_rlast  = 1'($urandom_range(0, 1));
      #1;
      check_eq("stray_rready", 64'(AXI_rready), 64'(1));
      check_eq("stray_rvalid", 64'(req_rvalid), 64'(0));
      check_eq("stray_rlast",  64'(req_rlast),  64'(0));
      note_err();
      @(negedge AXI_clk);
      check_eq("stray_len_err", 64'(len_err), 64'(1));
    end
    AXI_rvalid = 1'b0;
    AXI_rlast  = 1'b0;
    @(negedge AXI_clk);
    check_eq("stray_len_err_end", 64'(len_err), 64'(0));
    check_eq("stray_err_cnt",     64'(err_cnt), 64'(exp_err));
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_burst(input logic [NREQ-1:0] reqs, input int ar_wait,
                           input int nbeats, input int abort_at);
    int              g;
    int              beat;
    int              guard;
    bit              hs;
    bit              exp_le;
    logic [NREQ-1:0] oh;
    g  = rr_winner(reqs, exp_ptr);
    oh = onehot(g);
    for (int i = 0; i < NREQ; i++) req_araddr[i*ADDR_W +: ADDR_W] = addr_tab[i];
    req_arvalid = reqs;
    req_rready  = '0;
    AXI_arready = 1'b0;
    AXI_rvalid  = 1'b0;
    AXI_rlast   = 1'b0;
    @(negedge AXI_clk);
    check_eq("ar_valid_1cyc", 64'(AXI_arvalid), 64'(1));
    check_eq("grant",         64'(grant),       64'(oh));
    check_eq("ar_addr",       64'(AXI_araddr),  64'(addr_tab[g]));
    check_eq("ar_len",        64'(AXI_arlen),   64'(BURST_LEN - 1));
    check_eq("err_cnt_pre",   64'(err_cnt),     64'(exp_err));
    req_araddr[g*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    if ($urandom_range(0, 1) == 1) req_arvalid[g] = 1'b0;
    repeat (ar_wait) begin
      @(negedge AXI_clk);
      check_eq("ar_hold_valid", 64'(AXI_arvalid), 64'(1));
      check_eq("ar_hold_addr",  64'(AXI_araddr),  64'(addr_tab[g]));
      check_eq("ar_no_ready",   64'(req_arready), 64'(0));
    end
    AXI_arready = 1'b1;
    #1;
    check_eq("arready_route", 64'(req_arready), 64'(oh));
    @(negedge AXI_clk);
    check_eq("ar_drop",      64'(AXI_arvalid), 64'(0));
    check_eq("arready_data", 64'(req_arready), 64'(0));
    AXI_arready = 1'b0;
    beat   = 0;
    guard  = 0;
    while (beat < nbeats && guard < 500) begin
      guard++;
      if (beat == abort_at) begin
        AXI_rvalid  = 1'b0;
        AXI_rlast   = 1'b0;
        req_arvalid = '0;
        AXI_rst_n   = 1'b0;
        @(negedge AXI_clk);
        check_eq("abort_grant",   64'(grant),       64'(0));
        check_eq("abort_arvalid", 64'(AXI_arvalid), 64'(0));
        check_eq("abort_len_err", 64'(len_err),     64'(0));
        check_eq("abort_err_cnt", 64'(err_cnt),     64'(0));
        #1;
        check_eq("abort_rready",  64'(AXI_rready),  64'(1));
        check_eq("abort_rvalid",  64'(req_rvalid),  64'(0));
        AXI_rst_n = 1'b1;
        exp_ptr   = 0;
        exp_err   = 0;
        return;
      end
      AXI_rvalid = ($urandom_range(0, 3) != 0);
      AXI_rlast  = (beat == nbeats - 1);
      req_rready = NREQ'($urandom);
      if ($urandom_range(0, 3) != 0) req_rready[g] = 1'b1;
      #1;
      check_eq("r_ready_mux",   64'(AXI_rready), 64'(req_rready[g]));
      check_eq("r_valid_route", 64'(req_rvalid), 64'(oh & {NREQ{AXI_rvalid}}));
      check_eq("r_last_route",  64'(req_rlast),  64'(oh & {NREQ{AXI_rlast}}));
      hs     = AXI_rvalid && req_rready[g];
      exp_le = 1'b0;
      if (hs) begin
        if (beat == nbeats - 1) exp_le = (beat != BURST_LEN - 1);
        else                    exp_le = (beat == BURST_LEN - 1);
        if (exp_le) note_err();
        beat++;
      end
      @(negedge AXI_clk);
      check_eq("len_err", 64'(len_err), 64'(exp_le));
    end
    if (guard >= 500) check_eq("data_timeout", 64'(beat), 64'(nbeats));
    AXI_rvalid  = 1'b0;
    AXI_rlast   = 1'b0;
    req_rready  = '0;
    req_arvalid = '0;
    #1;
    check_eq("end_grant",   64'(grant),       64'(0));
    check_eq("end_arvalid", 64'(AXI_arvalid), 64'(0));
    check_eq("end_rready",  64'(AXI_rready),  64'(1));
    check_eq("end_rvalid",  64'(req_rvalid),  64'(0));
    check_eq("end_err_cnt", 64'(err_cnt),     64'(exp_err));
    exp_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    logic [NREQ-1:0] reqs;
    int              nb;
    int              sel;
    AXI_rst_n  = 1'b0;
    req_araddr = '0;
    drive_idle();
    for (int i = 0; i < NREQ; i++) addr_tab[i] = ADDR_W'($urandom);

    do_reset(3);

    addr_tab[0] = 32'h1000_0040;
    run_burst(3'b001, 2, 16, -1);

    do_reset(2);
    repeat (4) run_burst(3'b011, $urandom_range(0, 2), 16, -1);

    run_burst(3'b001, 0, 8, -1);
    stray(2);

    run_burst(3'b100, 1, 16, 5);
    run_burst(3'b010, 1, 16, -1);

    run_burst(3'b101, 0, 18, -1);
    run_burst(3'b111, 0, 1, -1);
    stray(7);

    for (int it = 0; it < 24; it++) begin
      if (it % 8 == 0) do_reset(2);
      for (int i = 0; i < NREQ; i++) addr_tab[i] = ADDR_W'($urandom);
      reqs = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      sel  = $urandom_range(0, 9);
      if (sel < 6)      nb = BURST_LEN;
      else if (sel < 8) nb = $urandom_range(1, BURST_LEN - 1);
      else              nb = $urandom_range(BURST_LEN + 1, BURST_LEN + 4);
      if ($urandom_range(0, 5) == 0) stray($urandom_range(1, 2));
      run_burst(reqs, $urandom_range(0, 3), nb, -1);
    end

    @(negedge AXI_clk);
    check_eq("len_err_pulses", 64'(n_pulses), 64'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
